decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_pkg.sv | 48 ++++
 rtl/decode_unit_regfile.sv | 37 +++
 rtl/decode_unit.sv | 153 +++++++++++++++
 tb/tb_decode_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: opcodes, instruction field positions and the ID/EX bundle.
package decode_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IR_W       = 13;
  localparam int PC_W       = 5;

  localparam int OP_HI  = 12;
  localparam int OP_LO  = 9;
  localparam int F1_HI  = 8;
  localparam int F1_LO  = 6;
  localparam int F2_HI  = 5;
  localparam int F2_LO  = 3;
  localparam int F3_HI  = 2;
  localparam int F3_LO  = 0;
  localparam int JMP_HI = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  // op is kept as raw bits so illegal encodings A-E pass through unchanged
  typedef struct packed {
    logic                  valid;
    logic [3:0]            op;
    logic [2:0]            rd;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [DATA_W_DEF-1:0] imm;
    logic [PC_W-1:0]       pc;
    logic                  illegal;
  } id_ex_t;

  function automatic logic [DATA_W_DEF-1:0] sext3(input logic [2:0] f);
    return {{(DATA_W_DEF-3){f[2]}}, f};
  endfunction

endpackage

// File: rtl/decode_unit_regfile.sv
// 8-entry register file, two combinational reads with write-through bypass, one synchronous write.
// R0 always reads zero and ignores writes.
module regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [2:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we && waddr != 3'd0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data = '0;
    if (ra_addr != 3'd0) ra_data = (we && waddr == ra_addr) ? wdata : regs[ra_addr];
  end

  always_comb begin
    rb_data = '0;
    if (rb_addr != 3'd0) rb_data = (we && waddr == rb_addr) ? wdata : regs[rb_addr];
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: IF/ID register, field decode with register read, load-use/halt hazard, ID/EX register.
// Latency ir_in -> dx_* is two edges; stall holds fetch for one cycle on load-use and forever once halted.
module decode_unit
  import decode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [12:0]       ir_in,
  input  logic [4:0]        pc_in,
  input  logic              ir_valid,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              halted,
  output logic              dx_valid,
  output logic [3:0]        dx_op,
  output logic [2:0]        dx_rd,
  output logic [DATA_W-1:0] dx_a,
  output logic [DATA_W-1:0] dx_b,
  output logic [DATA_W-1:0] dx_imm,
  output logic [4:0]        dx_pc,
  output logic              dx_illegal
);

  logic [IR_W-1:0] if_instr;
  logic [PC_W-1:0] if_pc;
  logic            if_valid;
  id_ex_t          dx_q;
  id_ex_t          dec;
  logic            halted_q;

  logic [3:0]        op;
  logic [2:0]        f1, f2, f3;
  logic [2:0]        ra_idx, rb_idx;
  logic              use_a, use_b;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic              load_use;

  assign op = if_instr[OP_HI:OP_LO];
  assign f1 = if_instr[F1_HI:F1_LO];
  assign f2 = if_instr[F2_HI:F2_LO];
  assign f3 = if_instr[F3_HI:F3_LO];

  regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .ra_addr (ra_idx),
    .ra_data (ra_data),
    .rb_addr (rb_idx),
    .rb_data (rb_data)
  );

  // Read-port selection and which ports are real sources (kept apart from the data mux to avoid a loop)
  always_comb begin
    ra_idx = f2;
    rb_idx = f3;
    use_a  = 1'b0;
    use_b  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      OP_ADDI, OP_LD: use_a = 1'b1;
      OP_ST: begin
        rb_idx = f1;
        use_a  = 1'b1;
        use_b  = 1'b1;
      end
      OP_BEQ: begin
        ra_idx = f1;
        rb_idx = f2;
        use_a  = 1'b1;
        use_b  = 1'b1;
      end
      default: ;
    endcase
    if (!if_valid) begin
      use_a = 1'b0;
      use_b = 1'b0;
    end
  end

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.op    = op;
    dec.pc    = if_pc;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.rd = f1;
        dec.a  = ra_data;
        dec.b  = rb_data;
      end
      OP_ADDI, OP_LD: begin
        dec.rd  = f1;
        dec.a   = ra_data;
        dec.imm = sext3(f3);
      end
      OP_ST, OP_BEQ: begin
        dec.a   = ra_data;
        dec.b   = rb_data;
        dec.imm = sext3(f3);
      end
      OP_JMP:          dec.imm = DATA_W_DEF'(if_instr[JMP_HI:0]);
      OP_HALT, OP_NOP: ;
      default:         dec.illegal = 1'b1;
    endcase
    if (!if_valid || op == OP_NOP) dec = '0;
  end

  assign load_use = dx_q.valid && dx_q.op == OP_LD && dx_q.rd != 3'd0 &&
                    ((use_a && ra_idx == dx_q.rd) || (use_b && rb_idx == dx_q.rd));
  assign stall    = load_use || halted_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
      dx_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      if (flush) begin
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_instr <= ir_in;
        if_pc    <= pc_in;
        if_valid <= ir_valid;
      end
      dx_q <= (flush || stall) ? id_ex_t'('0) : dec;
      if (!flush && !stall && dec.valid && dec.op == OP_HALT) halted_q <= 1'b1;
    end
  end

  assign halted     = halted_q;
  assign dx_valid   = dx_q.valid;
  assign dx_op      = dx_q.op;
  assign dx_rd      = dx_q.rd;
  assign dx_a       = dx_q.a;
  assign dx_b       = dx_q.b;
  assign dx_imm     = dx_q.imm;
  assign dx_pc      = dx_q.pc;
  assign dx_illegal = dx_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: per-cycle comparison against an instruction-level reference model,
// plus hand-computed literal expectations at key points of the sequence.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] ir_in;
  logic [4:0]  pc_in;
  logic        ir_valid;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        stall, halted, dx_valid, dx_illegal;
  logic [3:0]  dx_op;
  logic [2:0]  dx_rd;
  logic [7:0]  dx_a, dx_b, dx_imm;
  logic [4:0]  dx_pc;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  decode_unit #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_in      (ir_in),
    .pc_in      (pc_in),
    .ir_valid   (ir_valid),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .halted     (halted),
    .dx_valid   (dx_valid),
    .dx_op      (dx_op),
    .dx_rd      (dx_rd),
    .dx_a       (dx_a),
    .dx_b       (dx_b),
    .dx_imm     (dx_imm),
    .dx_pc      (dx_pc),
    .dx_illegal (dx_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       v;
    bit [3:0] op;
    bit [2:0] rd;
    bit [7:0] a, b, imm;
    bit [4:0] pc;
    bit       ill;
  } exp_t;

  bit [7:0]  m_regs [8];
  bit [12:0] m_if_ir  = '0;
  bit [4:0]  m_if_pc  = '0;
  bit        m_if_v   = 1'b0;
  exp_t      m_dx     = '0;
  bit        m_halt   = 1'b0;

  function automatic bit [7:0] rd_reg(input bit [2:0] r);
    if (r == 0) return 8'h00;
    if (wb_en && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit [7:0] sx3(input bit [2:0] f);
    int v;
    v = f[2] ? int'(f) - 8 : int'(f);
    return 8'(v);
  endfunction

  function automatic exp_t ref_decode(input bit [12:0] ir, input bit [4:0] pc, input bit v);
    exp_t e;
    int   op, f1, f2, f3;
    e  = '0;
    op = int'(ir[12:9]); f1 = int'(ir[8:6]); f2 = int'(ir[5:3]); f3 = int'(ir[2:0]);
    if (!v || op == 0) return e;
    e.v = 1; e.op = 4'(op); e.pc = pc;
    if (op >= 1 && op <= 4) begin
      e.rd = 3'(f1); e.a = rd_reg(3'(f2)); e.b = rd_reg(3'(f3));
    end else if (op == 5 || op == 6) begin
      e.rd = 3'(f1); e.a = rd_reg(3'(f2)); e.imm = sx3(3'(f3));
    end else if (op == 7) begin
      e.a = rd_reg(3'(f2)); e.b = rd_reg(3'(f1)); e.imm = sx3(3'(f3));
    end else if (op == 8) begin
      e.a = rd_reg(3'(f1)); e.b = rd_reg(3'(f2)); e.imm = sx3(3'(f3));
    end else if (op == 9) begin
      e.imm = 8'(ir[4:0]);
    end else if (op != 15) begin
      e.ill = 1;
    end
    return e;
  endfunction

  function automatic bit [7:0] src_mask(input bit [12:0] ir);
    int op, f1, f2, f3;
    op = int'(ir[12:9]); f1 = int'(ir[8:6]); f2 = int'(ir[5:3]); f3 = int'(ir[2:0]);
    if (op >= 1 && op <= 4) return (8'd1 << f2) | (8'd1 << f3);
    if (op == 5 || op == 6) return 8'd1 << f2;
    if (op == 7 || op == 8) return (8'd1 << f1) | (8'd1 << f2);
    return 8'd0;
  endfunction

  function automatic bit m_stall();
    bit [7:0] msk;
    msk = src_mask(m_if_ir);
    return m_halt || (m_if_v && m_dx.v && m_dx.op == 4'd6 && m_dx.rd != 0 && msk[m_dx.rd]);
  endfunction

  always @(posedge clk) begin : model
    exp_t nd;
    bit   st;
    if (!reset) begin
      m_if_v = 0; m_if_ir = 0; m_if_pc = 0; m_dx = '0; m_halt = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    end else begin
      st = m_stall();
      nd = (flush || st) ? exp_t'('0) : ref_decode(m_if_ir, m_if_pc, m_if_v);
      if (nd.v && nd.op == 4'hF) m_halt = 1;
      if (flush) m_if_v = 0;
      else if (!st) begin
        m_if_ir = ir_in; m_if_pc = pc_in; m_if_v = ir_valid;
      end
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      m_dx = nd;
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (chk_en) begin
      chk("cyc_stall",   stall,      m_stall());
      chk("cyc_halted",  halted,     m_halt);
      chk("cyc_valid",   dx_valid,   m_dx.v);
      chk("cyc_op",      dx_op,      m_dx.op);
      chk("cyc_rd",      dx_rd,      m_dx.rd);
      chk("cyc_a",       dx_a,       m_dx.a);
      chk("cyc_b",       dx_b,       m_dx.b);
      chk("cyc_imm",     dx_imm,     m_dx.imm);
      chk("cyc_pc",      dx_pc,      m_dx.pc);
      chk("cyc_illegal", dx_illegal, m_dx.ill);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [12:0] enc(input int op, input int f1, input int f2, input int f3);
    return {4'(op), 3'(f1), 3'(f2), 3'(f3)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [12:0] ir, input logic [4:0] pc);
    ir_in = ir; pc_in = pc; ir_valid = 1'b1;
  endtask

  task automatic wb(input logic en, input logic [2:0] a, input logic [7:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; ir_in = '0; pc_in = '0; ir_valid = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_valid", dx_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;

    // ADD with R2=5, R3=7
    wb(1, 2, 8'h05); step();
    wb(1, 3, 8'h07); step();
    wb(0, 0, 8'h00);
    fetch(13'h0253, 5'd1); step();
    fetch(13'h029A, 5'd2); step();
    chk("add_valid", dx_valid, 1);
    chk("add_op", dx_op, 1);
    chk("add_rd", dx_rd, 1);
    chk("add_a", dx_a, 8'h05);
    chk("add_b", dx_b, 8'h07);
    ir_valid = 1'b0; step();
    chk("add2_rd", dx_rd, 2);
    chk("add2_a", dx_a, 8'h07);
    chk("add2_b", dx_b, 8'h05);
    step();
    chk("idle_valid", dx_valid, 0);

    // bypass on R3, and wb to R0 leaves reads at zero
    fetch(enc(1, 4, 2, 3), 5'd3); step();
    ir_valid = 1'b0; wb(1, 3, 8'hA5); step();
    chk("byp_b", dx_b, 8'hA5);
    wb(0, 0, 8'h00);
    fetch(enc(2, 5, 0, 2), 5'd4); step();
    ir_valid = 1'b0; wb(1, 0, 8'h3C); step();
    chk("r0_a", dx_a, 8'h00);
    chk("r0_b", dx_b, 8'h05);
    wb(0, 0, 8'h00);

    // load-use: LD R4,R1,0 ; ADD R5,R4,R2
    fetch(enc(6, 4, 1, 0), 5'd6); step();
    fetch(enc(1, 5, 4, 2), 5'd7); step();
    chk("lu_ld_op", dx_op, 6);
    chk("lu_stall", stall, 1);
    step();
    chk("lu_bubble", dx_valid, 0);
    chk("lu_unstall", stall, 0);
    ir_valid = 1'b0; wb(1, 4, 8'h42); step();
    chk("lu_add_valid", dx_valid, 1);
    chk("lu_add_a", dx_a, 8'h42);
    chk("lu_add_pc", dx_pc, 7);
    wb(0, 0, 8'h00);

    // flush concurrent with load-use stall
    fetch(enc(6, 3, 2, 1), 5'd8); step();
    fetch(enc(8, 3, 1, 2), 5'd9); step();
    chk("fl_stall_before", stall, 1);
    flush = 1'b1; fetch(enc(1, 1, 2, 2), 5'd10); step();
    chk("fl_valid", dx_valid, 0);
    chk("fl_stall", stall, 0);
    flush = 1'b0; fetch(enc(3, 7, 2, 3), 5'd11); step();
    ir_valid = 1'b0; step();
    chk("fl_next_op", dx_op, 3);
    chk("fl_next_pc", dx_pc, 11);
    chk("fl_next_b", dx_b, 8'hA5);

    // ADDI sext, illegal, JMP, ST, NOP
    fetch(enc(5, 2, 1, 7), 5'd12); step();
    fetch(enc(4'hB, 1, 2, 3), 5'd13); step();
    chk("addi_imm", dx_imm, 8'hFF);
    chk("addi_rd", dx_rd, 2);
    fetch(enc(9, 0, 2, 6), 5'd14); step();
    chk("ill_flag", dx_illegal, 1);
    chk("ill_op", dx_op, 4'hB);
    chk("ill_valid", dx_valid, 1);
    chk("ill_rd", dx_rd, 0);
    fetch(enc(7, 3, 2, 5), 5'd15); step();
    chk("jmp_imm", dx_imm, 8'h16);
    fetch(enc(0, 1, 2, 3), 5'd16); step();
    chk("st_a", dx_a, 8'h05);
    chk("st_b", dx_b, 8'hA5);
    chk("st_imm", dx_imm, 8'hFD);
    chk("st_rd", dx_rd, 0);

    // HALT is sticky until reset
    fetch(enc(15, 0, 0, 0), 5'd17); step();
    chk("nop_valid", dx_valid, 0);
    fetch(enc(1, 1, 2, 3), 5'd18); step();
    chk("halt_op", dx_op, 4'hF);
    chk("halt_flag", halted, 1);
    chk("halt_stall", stall, 1);
    step(); step();
    chk("halt_hold", halted, 1);
    chk("halt_bubble", dx_valid, 0);
    reset = 1'b0; step();
    chk("halt_rst", halted, 0);
    chk("halt_rst_stall", stall, 0);
    reset = 1'b1; fetch(enc(1, 1, 2, 3), 5'd19); step();
    ir_valid = 1'b0; step();
    chk("post_rst_valid", dx_valid, 1);
    chk("post_rst_pc", dx_pc, 19);
    chk("post_rst_a", dx_a, 8'h00);

    // flush in the HALT capture cycle wins
    fetch(enc(15, 0, 0, 0), 5'd20); step();
    ir_valid = 1'b0; flush = 1'b1; step();
    chk("halt_fl_halted", halted, 0);
    chk("halt_fl_valid", dx_valid, 0);
    flush = 1'b0; step(); step();
    chk("halt_fl_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
